// File: rtl/cad_pkg.sv
// Shared definitions for the CAD result deserializer: word geometry,
// bit-counter sizing and the burst-tracking state encoding.
package cad_pkg;

  localparam int WORD_W = 20;
  localparam int CNT_W  = 5;
  localparam int WCNT_W = 11;

  // Bit index of the final serial bit of a word
  localparam logic [CNT_W-1:0] LAST_BIT = 5'd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    END  = 2'd2
  } state_t;

endpackage

// File: rtl/cad_sync_fifo.sv
// Synchronous word FIFO for the deserializer output. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; otherwise
// the push is ignored and the contents are left untouched.
module cad_sync_fifo
  import cad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_din,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rptr];

  // Read/write pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Word storage; contents are meaningless while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/cad_out_deser.sv
// Serial-to-parallel converter for the CAD core result stream: assembles
// 20-bit LSB-first words, buffers them in a small FIFO, and flags framing
// and overflow errors. Defining CAD_DESER_WCNT_EN adds a per-burst
// complete-word counter output (word_cnt).
module cad_out_deser
  import cad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     out_valid,
  output logic signed [WORD_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     burst_done,
  output logic                     frame_err,
  output logic                     ovf_err
`ifdef CAD_DESER_WCNT_EN
  ,
  output logic [WCNT_W-1:0]        word_cnt
`endif
);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-2:0] r_asm;
  logic              r_got_word;
  logic              r_burst_ferr;
  logic              w_last;
  logic              w_frame_fall;
  logic              w_burst_start;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_fifo_dout;

  assign w_last        = in_valid && (r_bit_cnt == LAST_BIT);
  assign w_frame_fall  = !in_valid && (r_bit_cnt != '0);
  assign w_burst_start = (r_state == IDLE) && in_valid;
  assign w_word        = {in_bit, r_asm};
  assign out_valid     = !w_empty;
  assign w_pop         = out_valid && out_ready;
  assign out_data      = w_empty ? '0 : w_fifo_dout;

  cad_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_last),
    .i_din   (w_word),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Burst state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Burst tracking; burst_done is reported during the single END cycle
  always_comb begin
    w_next_state = r_state;
    burst_done   = 1'b0;
    case (r_state)
      IDLE: if (in_valid)  w_next_state = RECV;
      RECV: if (!in_valid) w_next_state = END;
      END: begin
        w_next_state = IDLE;
        burst_done   = r_got_word && !r_burst_ferr;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Bit position within the word; wraps 19->0 and clears when the stream stops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_bit_cnt <= '0;
    else if (w_last)   r_bit_cnt <= '0;
    else if (in_valid) r_bit_cnt <= r_bit_cnt + 1'b1;
    else               r_bit_cnt <= '0;
  end

  // Shift register holding bits 0..18; after 19 shifts bit 0 sits at the LSB
  always_ff @(posedge clk) begin
    if (in_valid) r_asm <= {in_bit, r_asm[WORD_W-2:1]};
  end

  // Sticky error flags and per-burst bookkeeping for burst_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err    <= 1'b0;
      ovf_err      <= 1'b0;
      r_got_word   <= 1'b0;
      r_burst_ferr <= 1'b0;
    end else begin
      if (w_frame_fall)                 frame_err <= 1'b1;
      if (w_last && w_full && !w_pop)   ovf_err   <= 1'b1;
      if (w_burst_start) begin
        r_got_word   <= 1'b0;
        r_burst_ferr <= 1'b0;
      end
      if (w_last)       r_got_word   <= 1'b1;
      if (w_frame_fall) r_burst_ferr <= 1'b1;
    end
  end

`ifdef CAD_DESER_WCNT_EN
  // Complete words in the current burst, saturating, held once the burst ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          word_cnt <= '0;
    else if (w_burst_start)              word_cnt <= '0;
    else if (w_last && (word_cnt != '1)) word_cnt <= word_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cad_out_deser.sv
// Self-checking bench for cad_out_deser: directed scenarios plus random
// bursts, with a queue-based reference model and a negedge monitor.
module tb_cad_out_deser;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [19:0] out_data;
  logic        burst_done;
  logic        frame_err;
  logic        ovf_err;
`ifdef CAD_DESER_WCNT_EN
  logic [10:0] word_cnt;
`endif

  cad_out_deser #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .burst_done (burst_done),
    .frame_err  (frame_err),
    .ovf_err    (ovf_err)
`ifdef CAD_DESER_WCNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [19:0] mq[$];
  int          nb = 0;
  logic [19:0] acc = '0;
  bit          prev_v = 0;
  bit          got_b = 0;
  bit          ferr_b = 0;
  bit          exp_bd = 0;
  bit          exp_ferr = 0;
  bit          exp_ovf = 0;
  int          exp_wc = 0;
  bit          m_pop, m_full, m_push;
  logic [19:0] m_word;
  bit          rnd_ready = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collect serial bits into words, keep a bounded queue
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        mq.delete();
        nb = 0; acc = '0; prev_v = 0; got_b = 0; ferr_b = 0;
        exp_bd = 0; exp_ferr = 0; exp_ovf = 0; exp_wc = 0;
      end else begin
        m_pop  = (mq.size() > 0) && (out_ready === 1'b1);
        m_full = (mq.size() == DEPTH);
        m_push = 0;
        exp_bd = 0;
        if (in_valid) begin
          if (!prev_v) begin got_b = 0; ferr_b = 0; exp_wc = 0; end
          if (in_bit) acc = acc + (20'd1 << nb);
          nb++;
          if (nb == 20) begin
            m_push = 1; m_word = acc; nb = 0; acc = '0; got_b = 1;
            if (exp_wc < 2047) exp_wc++;
          end
        end else begin
          if (nb != 0) begin exp_ferr = 1; ferr_b = 1; nb = 0; acc = '0; end
          if (prev_v) exp_bd = got_b && !ferr_b;
        end
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          if (m_full && !m_pop) exp_ovf = 1;
          else mq.push_back(m_word);
        end
        prev_v = in_valid;
      end
    end
  end

  // Monitor: compare DUT outputs against the model every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) check("out_data", {12'b0, out_data}, {12'b0, mq[0]});
        else                check("out_data_idle", {12'b0, out_data}, 32'd0);
        check("burst_done", {31'b0, burst_done}, {31'b0, exp_bd});
        check("frame_err", {31'b0, frame_err}, {31'b0, exp_ferr});
        check("ovf_err", {31'b0, ovf_err}, {31'b0, exp_ovf});
`ifdef CAD_DESER_WCNT_EN
        check("word_cnt", {21'b0, word_cnt}, exp_wc);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bits(input logic [19:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
    end
  endtask

  task automatic send_word(input logic [19:0] w);
    send_bits(w, 20);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_bit = 1'($urandom);
      tick();
    end
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {12'b0, out_data}, 32'd0);
    check({tag, "_burst_done"}, {31'b0, burst_done}, 32'd0);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
    check({tag, "_ovf_err"}, {31'b0, ovf_err}, 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    zero_checks("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [19:0] w5;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    zero_checks("por");
    rst_n = 1'b1;
    idle(2);

    // Single word, consumer always ready
    send_word(20'h12345);
    idle(4);

    // Back-to-back words
    send_word(20'h00001);
    send_word(20'hFFFFF);
    send_word(20'h80000);
    idle(4);

    // Overflow: five words into a four-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(20'(32'h11111 * (i + 1)));
    idle(3);
    check("ovf_set", {31'b0, ovf_err}, 32'd1);
    out_ready = 1'b1;
    idle(8);
    do_reset();

    // Framing error after 7 bits
    send_bits(20'h5A5A5, 7);
    idle(4);
    check("ferr_set", {31'b0, frame_err}, 32'd1);
    do_reset();

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(20'(32'h2468A + i));
    w5 = 20'h7C3E1;
    send_bits(w5, 19);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = w5[19];
    tick();
    out_ready = 1'b0;
    idle(2);
    check("ovf_clear", {31'b0, ovf_err}, 32'd0);
    out_ready = 1'b1;
    idle(8);

    // Reset mid-word with two words buffered
    out_ready = 1'b0;
    send_word(20'h13579);
    send_word(20'h2468A);
    send_bits(20'hFEDCB, 10);
    do_reset();
    out_ready = 1'b1;
    idle(1);
    send_word(20'h0ABCD);
    idle(4);

    // Random bursts with a randomly stalling consumer
    do_reset();
    rnd_ready = 1;
    for (int b = 0; b < 30; b++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++) send_word(20'($urandom));
      if ($urandom_range(0, 5) == 0) send_bits(20'($urandom), $urandom_range(1, 19));
      idle($urandom_range(2, 4));
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    idle(10);
    check("drained", mq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cad_out_deser.md
CAD_OUT_DESER -- requirements
Module: cad_out_deser

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: in_valid  input  1  serial result stream valid; driven by the upstream CAD core's out_valid.
REQ-004 SHALL have port: in_bit  input  1  serial result bit, LSB first, 20 bits per word; driven by the CAD core's out_value.
REQ-005 SHALL have port: out_valid  output  1  parallel word available at FIFO head.
REQ-006 SHALL have port: out_data  output  20  signed result word at FIFO head; 0 when out_valid=0.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts the word; a transfer occurs when out_valid && out_ready.
REQ-008 SHALL have port: burst_done  output  1  one-cycle pulse at end of a result burst.
REQ-009 SHALL have port: frame_err  output  1  sticky; in_valid fell mid-word.
REQ-010 SHALL have port: ovf_err  output  1  sticky; completed word dropped because FIFO full.
REQ-011 SHALL have parameter: DEPTH, default 4, FIFO depth in words (power of 2, >=2).

Function
REQ-012 SHALL sample in_bit when in_valid=1 and shift it into bit position bit_cnt (0..19) of the assembly register.
REQ-013 SHALL, on the cycle the 20th bit (bit_cnt=19) is sampled, push {in_bit, asm[18:0]} into the FIFO, set bit_cnt to 0, and assert out_valid in the next cycle if FIFO was empty (1-cycle latency from last bit to out_valid).
REQ-014 SHALL accept back-to-back words with no gap; bit_cnt wraps 19->0 without an idle cycle.
REQ-015 SHALL, when a push and a pop occur in the same cycle with FIFO full, perform both with no overflow.
REQ-016 SHALL, when a push occurs with FIFO full and no pop, drop the word, set ovf_err, and leave FIFO contents unchanged.
REQ-017 SHALL, when in_valid falls with bit_cnt!=0, discard the partial word, clear bit_cnt, and set frame_err.
REQ-018 SHALL use states IDLE (no burst), RECV (in_valid=1), END (in_valid fell); IDLE->RECV on in_valid=1; RECV->END on in_valid=0; END->IDLE unconditionally next cycle.
REQ-019 SHALL pulse burst_done for exactly one cycle while in END, only if at least one complete word was received in the burst and no frame error occurred in it.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL keep frame_err and ovf_err set until rst_n asserts.

Reset
REQ-022 SHALL, on rst_n=0, immediately force out_valid=0, out_data=0, burst_done=0, frame_err=0, ovf_err=0, bit_cnt=0, FIFO empty, state IDLE.
REQ-023 SHALL, on reset mid-word or mid-burst, discard all partial and buffered data; no burst_done after release.

Configuration
REQ-024 SHALL, with macro CAD_DESER_WCNT_EN defined, add output word_cnt (11 bits) counting complete words in the current burst, cleared on IDLE->RECV, saturating at 2047, held after burst end.
REQ-025 SHALL, without CAD_DESER_WCNT_EN, omit the word_cnt port and its counter entirely.

Structure
REQ-026 SHALL place the word width (20), the bit-counter width, and the state enum in shared package cad_pkg.
REQ-027 SHALL implement buffering in one sub-module cad_sync_fifo (DEPTH x 20, full/empty flags, simultaneous push/pop).

Verification
REQ-028 SHALL cover: one burst, 20 bits of 0x12345 LSB-first, out_ready=1 -> out_data=0x12345 one cycle after last bit, burst_done pulses once.
REQ-029 SHALL cover: 3 back-to-back words 0x00001, 0xFFFFF, 0x80000 -> words emitted in order, no gap needed between inputs.
REQ-030 SHALL cover: out_ready=0, 5 words with DEPTH=4 -> first 4 retained, 5th dropped, ovf_err=1.
REQ-031 SHALL cover: in_valid falls after 7 bits -> nothing pushed, frame_err=1, burst_done stays 0.
REQ-032 SHALL cover: FIFO full, push and pop in the same cycle -> ovf_err stays 0, count unchanged.
REQ-033 SHALL cover: rst_n pulsed low after 10 bits with 2 words buffered -> all outputs 0 immediately, next clean word 0x0ABCD delivered correctly.
